// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between three byte-stream
// requesters. A requester keeps the grant for a whole message (message lock)
// and loses it when it finishes its last byte or stalls for HOLD_TIMEOUT
// idle clocks. Message starts are arbitrated round-robin. All outputs are
// registered.
module uart_tx_arbiter #(
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] req_byte,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ack,
  output logic [2:0]  msg_done,
  output logic [2:0]  abort,
  output logic [7:0]  tx_byte,
  output logic        tx_dv,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic [1:0]  grant_id,
  output logic        busy
);

  localparam int CNT_W = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [1:0] NO_OWNER = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_dv_q, tx_dv_d;
  logic [2:0]         req_ack_q, req_ack_d;
  logic [2:0]         msg_done_q, msg_done_d;
  logic [2:0]         abort_q, abort_d;
  logic               busy_q, busy_d;

  // Next requester index in the cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] inc3(input logic [1:0] id);
    inc3 = (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // One-hot vector for a requester index; NO_OWNER maps to all zeros.
  function automatic logic [2:0] id_bit(input logic [1:0] id);
    case (id)
      2'd0:    id_bit = 3'b001;
      2'd1:    id_bit = 3'b010;
      2'd2:    id_bit = 3'b100;
      default: id_bit = 3'b000;
    endcase
  endfunction

  // Byte lane of the given requester.
  function automatic logic [7:0] byte_sel(input logic [23:0] b, input logic [1:0] id);
    case (id)
      2'd0:    byte_sel = b[7:0];
      2'd1:    byte_sel = b[15:8];
      default: byte_sel = b[23:16];
    endcase
  endfunction

  // Round-robin pick: first set request at ptr, ptr+1, ptr+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] c0, c1, c2;
    c0 = ptr;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (|(r & id_bit(c0)))      rr_pick = c0;
    else if (|(r & id_bit(c1))) rr_pick = c1;
    else if (|(r & id_bit(c2))) rr_pick = c2;
    else                        rr_pick = NO_OWNER;
  endfunction

  logic grant_req;
  logic grant_last;
  logic hold_expired;

  assign grant_req    = |(req & id_bit(grant_q));
  assign grant_last   = |(req_last & id_bit(grant_q));
  assign hold_expired = (hold_cnt_q == CNT_W'(HOLD_TIMEOUT - 1));

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    req_ack_d  = 3'b000;
    msg_done_d = 3'b000;
    abort_d    = 3'b000;

    case (state_q)
      IDLE: begin
        if ((|req) && !tx_active) begin
          grant_d = rr_pick(req, rr_ptr_q);
          state_d = SEND;
        end
      end

      SEND: begin
        // Launch only into an idle transmitter; a late busy just delays launch.
        if (!tx_active) begin
          tx_byte_d = byte_sel(req_byte, grant_q);
          tx_dv_d   = 1'b1;
          req_ack_d = id_bit(grant_q);
          last_d    = grant_last;
          state_d   = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (tx_done) begin
          if (last_q) begin
            msg_done_d = id_bit(grant_q);
            rr_ptr_d   = inc3(grant_q);
            grant_d    = NO_OWNER;
            state_d    = IDLE;
          end else begin
            hold_cnt_d = '0;
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        // Other requesters are ignored here: the grant is locked to the message.
        if (grant_req) begin
          if (!tx_active) state_d = SEND;
        end else if (hold_expired) begin
          abort_d  = id_bit(grant_q);
          rr_ptr_d = inc3(grant_q);
          grant_d  = NO_OWNER;
          state_d  = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = NO_OWNER;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset returns everything to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      grant_q    <= NO_OWNER;
      last_q     <= 1'b0;
      hold_cnt_q <= '0;
      tx_byte_q  <= 8'h00;
      tx_dv_q    <= 1'b0;
      req_ack_q  <= 3'b000;
      msg_done_q <= 3'b000;
      abort_q    <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      req_ack_q  <= req_ack_d;
      msg_done_q <= msg_done_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign msg_done = msg_done_q;
  assign abort    = abort_q;
  assign tx_byte  = tx_byte_q;
  assign tx_dv    = tx_dv_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester agents feed per-requester message
// queues, a UART model answers each launch, and a transaction-level model
// predicts grant order, launched bytes, completions and aborts.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_byte;
  logic [2:0]  req_last;
  logic [2:0]  req_ack;
  logic [2:0]  msg_done;
  logic [2:0]  abort;
  logic [7:0]  tx_byte;
  logic        tx_dv;
  logic        tx_active;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.HOLD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_byte(req_byte), .req_last(req_last),
    .req_ack(req_ack), .msg_done(msg_done), .abort(abort), .tx_byte(tx_byte),
    .tx_dv(tx_dv), .tx_active(tx_active), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy)
  );

  // Per-requester pending bytes: bit 8 = last-of-message, bits 7:0 = data.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ucnt = 0;
  bit stray = 0;
  bit chk_rst = 0;
  int exp_ptr = 0;
  int owner = -1;
  bit done_pend = 0;
  bit dv_prev = 0;
  logic [7:0] exp_tx_byte = 8'h00;
  int n_dv = 0, n_done = 0, n_abort = 0;
  int last_dv_cyc = 0, last_done_cyc = 0, abort_gap = 0;
  int grant_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [8:0] qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int i, input logic [8:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  // Agents present the head of their queue; request is high while bytes remain.
  task automatic drive_reqs();
    logic [2:0]  r;
    logic [2:0]  l;
    logic [23:0] b;
    logic [8:0]  f;
    r = '0; l = '0; b = '0;
    for (int i = 0; i < 3; i++) begin
      if (qsize(i) > 0) begin
        f = qfront(i);
        r[i] = 1'b1;
        l[i] = f[8];
        b[8*i +: 8] = f[7:0];
      end
    end
    req = r; req_last = l; req_byte = b;
  endtask

  // Round-robin winner among requesters with pending bytes.
  function automatic int model_pick();
    for (int k = 0; k < 3; k++) begin
      if (qsize((exp_ptr + k) % 3) > 0) return (exp_ptr + k) % 3;
    end
    return -1;
  endfunction

  // One clock: sample/check outputs at the falling edge, then drive inputs.
  task automatic tick();
    int w;
    logic [8:0] item;
    @(negedge clk);
    cyc++;
    if (chk_rst) begin
      chk_rst = 0;
      check("rst_tx_dv", tx_dv, 0);
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_req_ack", req_ack, 0);
      check("rst_msg_done", msg_done, 0);
      check("rst_abort", abort, 0);
      check("rst_grant_id", grant_id, 3);
      check("rst_busy", busy, 0);
      exp_tx_byte = 8'h00;
      dv_prev = 0;
    end
    if (req_ack != 0) check("ack_onehot", $countones(req_ack), 1);
    if (msg_done != 0) check("done_onehot", $countones(msg_done), 1);
    if (abort != 0) check("abort_onehot", $countones(abort), 1);
    if (tx_dv || req_ack != 0) begin
      n_dv++;
      last_dv_cyc = cyc;
      check("dv_with_ack", {tx_dv, |req_ack}, 2'b11);
      check("dv_tx_active", tx_active, 0);
      check("dv_back_to_back", dv_prev, 0);
      check("ack_before_done", done_pend, 0);
      check("busy_at_launch", busy, 1);
      w = (owner < 0) ? model_pick() : owner;
      if (w < 0) begin
        check("unexpected_launch", req_ack, 0);
      end else begin
        item = qfront(w);
        check("ack_id", req_ack, 32'(1 << w));
        check("launch_byte", tx_byte, item[7:0]);
        check("grant_at_launch", grant_id, w);
        exp_tx_byte = item[7:0];
        grant_log.push_back(w);
        qpop(w);
        owner = w;
        done_pend = item[8];
      end
    end else begin
      check("tx_byte_hold", tx_byte, exp_tx_byte);
    end
    if (msg_done != 0) begin
      n_done++;
      check("msg_done_id", msg_done, (owner >= 0 && done_pend) ? 32'(1 << owner) : 0);
      check("done_grant_free", grant_id, 3);
      if (owner >= 0) exp_ptr = (owner + 1) % 3;
      owner = -1;
      done_pend = 0;
    end
    if (abort != 0) begin
      n_abort++;
      abort_gap = cyc - last_done_cyc;
      check("abort_id", abort, (owner >= 0 && !done_pend) ? 32'(1 << owner) : 0);
      check("abort_grant_free", grant_id, 3);
      if (owner >= 0) exp_ptr = (owner + 1) % 3;
      owner = -1;
    end
    dv_prev = tx_dv;
    // UART model: busy for 10 cycles per launch, done on the last one.
    if (tx_dv) ucnt = 10;
    if (ucnt > 0) begin
      tx_active = 1'b1;
      tx_done = (ucnt == 1);
      if (ucnt == 1) last_done_cyc = cyc;
      ucnt--;
    end else begin
      tx_active = 1'b0;
      tx_done = stray;
    end
    stray = 0;
    drive_reqs();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    drive_reqs();
    owner = -1; done_pend = 0; exp_ptr = 0;
    chk_rst = 1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(owner < 0 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
             ucnt == 0 && busy == 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < budget, 1);
  endtask

  task automatic expect_log(input string tag, input int a[4], input int len);
    check({tag, "_len"}, grant_log.size(), len);
    for (int i = 0; i < len && i < grant_log.size(); i++)
      check({tag, "_order"}, grant_log[i], a[i]);
  endtask

  initial begin
    int k, d0, v0, a0, len, n;
    int order[4];
    rst = 1'b1; req = '0; req_byte = '0; req_last = '0;
    tx_active = 1'b0; tx_done = 1'b0;
    chk_rst = 1;
    tick();
    rst = 1'b0;
    tick();

    // Single-byte message from requester 0: latency, byte, completion.
    q0.push_back(9'h141);
    drive_reqs();
    k = cyc; d0 = n_done; v0 = n_dv;
    n = 0;
    while (n_dv == v0 && n < 10) begin tick(); n++; end
    check("first_launch_latency", last_dv_cyc - k, 2);
    wait_idle(60);
    check("single_msg_done_count", n_done - d0, 1);

    // Requester 1 sends "OK\n" while requester 0 waits; pointer is now 1.
    grant_log.delete();
    q1.push_back(9'h04F); q1.push_back(9'h04B); q1.push_back(9'h10A);
    q0.push_back(9'h130);
    drive_reqs();
    wait_idle(200);
    order = '{1, 1, 1, 0};
    expect_log("msg_lock", order, 4);

    // Reset, then all three request with single-byte messages.
    pulse_reset();
    grant_log.delete();
    q0.push_back(9'h1A0); q0.push_back(9'h1A1);
    q1.push_back(9'h1B0); q2.push_back(9'h1C0);
    drive_reqs();
    wait_idle(250);
    order = '{0, 1, 2, 0};
    expect_log("round_robin", order, 4);

    // Requester 2 stalls after a non-last byte; pointer is 1 so 2 wins first.
    grant_log.delete();
    a0 = n_abort;
    q2.push_back(9'h055);
    q0.push_back(9'h166);
    drive_reqs();
    wait_idle(200);
    check("abort_count", n_abort - a0, 1);
    check("abort_timing", abort_gap, 17);
    order = '{2, 0, 0, 0};
    expect_log("after_abort", order, 2);

    // Randomized rounds, with stray tx_done pulses while idle.
    for (int r = 0; r < 8; r++) begin
      stray = 1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 1 || (i == 2 && qsize(0) + qsize(1) == 0)) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            qpush(i, {(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255))});
        end
      end
      drive_reqs();
      wait_idle(400);
    end

    // Reset in the middle of a multi-byte message.
    q1.push_back(9'h011); q1.push_back(9'h022); q1.push_back(9'h133);
    drive_reqs();
    v0 = n_dv; n = 0;
    while (n_dv == v0 && n < 10) begin tick(); n++; end
    check("mid_msg_launch_seen", n_dv - v0, 1);
    tick(); tick(); tick();
    pulse_reset();
    d0 = n_done; v0 = n_dv;
    for (int i = 0; i < 15; i++) tick();
    check("stray_done_after_reset", n_done - d0, 0);
    check("no_launch_after_reset", n_dv - v0, 0);
    check("grant_free_after_reset", grant_id, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
